fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 37 +++
 rtl/fetch_stage_if.sv | 11 +
 rtl/fetch_skid_buf.sv | 31 +++
 rtl/fetch_stage.sv | 95 +++++++++
 tb/tb_fetch_stage.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: control/IF-ID
// structures, next-pc select encodings and fetch FSM states.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        NEXT_PC_SEL_PC_4    = 2'd0,
        NEXT_PC_SEL_ALU_OUT = 2'd1
    } next_pc_sel_e;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        next_pc_sel_e next_pc_sel;
        logic         if_id_reg_stall;
        logic         if_id_reg_valid;
    } pipeline_if_ctrl_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } pipeline_if_id_reg_t;

    function automatic pipeline_if_id_reg_t if_id_entry(logic valid, logic [31:0] pc,
                                                        logic [31:0] instr);
        pipeline_if_id_reg_t r;
        r.valid = valid;
        r.pc    = pc;
        r.instr = instr;
        return r;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and memory.
interface fetch_stage_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (output req_valid, addr, input req_ready, rsp_valid, rsp_data);
    modport slave  (input req_valid, addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for a fetched instruction that arrived while IF/ID was stalled.
module fetch_skid_buf (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_instr,
    output logic        full,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            full  <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (push) begin
            full  <= 1'b1;
            pc    <= push_pc;
            instr <= push_instr;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: single-outstanding memory requests, redirect handling
// with stale-response dropping, and a skid slot so a stalled IF/ID loses nothing.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  pipeline_if_ctrl_t   if_ctrl_i,
    input  logic [31:0]         alu_out_i,
    fetch_stage_if.master       imem,
    output pipeline_if_id_reg_t if_id_reg_o
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt, pend_pc;
    logic [31:0]  redirect_pc, skid_pc, skid_instr;
    logic         redirect, stall, hs, rsp_wait;
    logic         skid_full, skid_push, skid_pop;

    assign redirect    = if_ctrl_i.next_pc_sel == NEXT_PC_SEL_ALU_OUT;
    assign redirect_pc = alu_out_i & ~32'h3;
    assign stall       = if_ctrl_i.if_id_reg_stall;

    // Gated by reset so no request is visible while reset is held.
    assign imem.req_valid = reset_ni && (state == FETCH_REQ) && !skid_full;
    assign imem.addr      = pc;
    assign hs             = imem.req_valid && imem.req_ready;
    assign rsp_wait       = (state == FETCH_WAIT) && imem.rsp_valid;

    assign skid_push = rsp_wait && stall && !redirect;
    assign skid_pop  = skid_full && !stall && !redirect;

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH_REQ:  if (hs) state_nxt = redirect ? FETCH_DROP : FETCH_WAIT;
            FETCH_WAIT: begin
                if (imem.rsp_valid)  state_nxt = FETCH_REQ;
                else if (redirect)   state_nxt = FETCH_DROP;
            end
            FETCH_DROP: if (imem.rsp_valid) state_nxt = FETCH_REQ;
            default:    state_nxt = FETCH_REQ;
        endcase
    end

    // A redirect wins over pc+4 even when it coincides with a handshake.
    always_comb begin
        pc_nxt = pc;
        if (redirect)  pc_nxt = redirect_pc;
        else if (hs)   pc_nxt = pc + 32'd4;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state   <= FETCH_REQ;
            pc      <= RESET_PC;
            pend_pc <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (hs) pend_pc <= pc;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            if_id_reg_o <= '0;
        end else if (redirect) begin
            if_id_reg_o.valid <= 1'b0;
        end else if (!stall) begin
            if (skid_full)
                if_id_reg_o <= if_id_entry(if_ctrl_i.if_id_reg_valid, skid_pc, skid_instr);
            else if (rsp_wait)
                if_id_reg_o <= if_id_entry(if_ctrl_i.if_id_reg_valid, pend_pc, imem.rsp_data);
            else
                if_id_reg_o.valid <= 1'b0;
        end
    end

    fetch_skid_buf u_skid (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .push       (skid_push),
        .pop        (skid_pop),
        .clear      (redirect),
        .push_pc    (pend_pc),
        .push_instr (imem.rsp_data),
        .full       (skid_full),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a memory model checks request addresses, a
// monitor checks every newly loaded IF/ID entry against hand-computed queues.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic                clk_i = 1'b0;
    logic                reset_ni = 1'b0;
    pipeline_if_ctrl_t   ctrl;
    logic [31:0]         alu_out;
    pipeline_if_id_reg_t ifid;

    fetch_stage_if imem();

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .if_ctrl_i   (ctrl),
        .alu_out_i   (alu_out),
        .imem        (imem),
        .if_id_reg_o (ifid)
    );

    always #5 clk_i = ~clk_i;

    int          total = 0, bad = 0, cyc = 0, delay = 1, left = 0;
    logic [31:0] exp_addr[$], exp_pc[$], exp_instr[$];
    int          vcyc[$];
    logic [31:0] paddr = '0;
    logic        stall_q = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Memory returns the bitwise inverse of the address as the instruction word.
    task automatic push_ifid(logic [31:0] pc);
        exp_pc.push_back(pc);
        exp_instr.push_back(~pc);
    endtask

    // Memory model: accepts on handshake, answers `delay` edges later.
    initial begin
        logic        hs;
        logic [31:0] a;
        imem.rsp_valid = 1'b0;
        imem.rsp_data  = '0;
        forever begin
            @(negedge clk_i);
            hs = imem.req_valid && imem.req_ready;
            a  = imem.addr;
            if (hs) begin
                if (exp_addr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL req_addr: unexpected request at %h (cycle %0d)", a, cyc);
                end else begin
                    chk("req_addr", a, exp_addr.pop_front());
                end
            end
            @(posedge clk_i);
            #1;
            if (hs) begin
                left  = delay;
                paddr = a;
            end
            if (left == 1) begin
                imem.rsp_valid = 1'b1;
                imem.rsp_data  = ~paddr;
                left = 0;
            end else begin
                imem.rsp_valid = 1'b0;
                if (left > 0) left--;
            end
        end
    end

    // Monitor: an entry is new when valid and the stall seen at the last edge was low.
    initial begin
        forever begin
            @(negedge clk_i);
            if (reset_ni && ifid.valid && !stall_q) begin
                vcyc.push_back(cyc);
                if (exp_pc.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ifid: unexpected entry pc %h (cycle %0d)", ifid.pc, cyc);
                end else begin
                    chk("ifid_pc", ifid.pc, exp_pc.pop_front());
                    chk("ifid_instr", ifid.instr, exp_instr.pop_front());
                end
            end
            stall_q = ctrl.if_id_reg_stall;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        ctrl.next_pc_sel     = NEXT_PC_SEL_PC_4;
        ctrl.if_id_reg_stall = 1'b0;
        ctrl.if_id_reg_valid = 1'b1;
        alu_out              = '0;
        imem.req_ready       = 1'b0;

        // Reset state
        step(2);
        chk("rst_req_valid", imem.req_valid, 0);
        chk("rst_ifid_valid", ifid.valid, 0);
        chk("rst_ifid_pc", ifid.pc, 0);
        chk("rst_ifid_instr", ifid.instr, 0);

        // Streaming fetch, 1-cycle latency: 0x0, 0x4, 0x8
        #2 reset_ni = 1'b1;
        imem.req_ready = 1'b1;
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h8);
        push_ifid(32'h0); push_ifid(32'h4); push_ifid(32'h8);
        #1;
        chk("first_req_valid", imem.req_valid, 1);
        chk("first_req_addr", imem.addr, RST_PC);
        step(5);
        imem.req_ready = 1'b0;
        step(3);
        if (vcyc.size() == 3) begin
            chk("ifid_gap0", vcyc[1] - vcyc[0], 2);
            chk("ifid_gap1", vcyc[2] - vcyc[1], 2);
        end else begin
            total++;
            bad++;
            $display("FAIL ifid_count: got %0d entries expected 3", vcyc.size());
        end
        vcyc.delete();

        // Stall for 3 cycles while a response arrives: it goes to the skid slot
        imem.req_ready = 1'b1;
        exp_addr.push_back(32'hC); exp_addr.push_back(32'h10); exp_addr.push_back(32'h14);
        push_ifid(32'hC); push_ifid(32'h10); push_ifid(32'h14);
        step(2);
        ctrl.if_id_reg_stall = 1'b1;
        step(2);
        chk("stall_no_req", imem.req_valid, 0);
        chk("stall_hold_valid", ifid.valid, 1);
        chk("stall_hold_pc", ifid.pc, 32'hC);
        step(1);
        chk("stall_no_req2", imem.req_valid, 0);
        ctrl.if_id_reg_stall = 1'b0;
        step(1);
        chk("release_ifid_pc", ifid.pc, 32'h10);
        chk("release_req_valid", imem.req_valid, 1);
        chk("release_req_addr", imem.addr, 32'h14);
        step(1);
        imem.req_ready = 1'b0;
        step(3);

        // Redirect to 0x103 in WAIT, response two cycles later is dropped
        delay = 3;
        imem.req_ready = 1'b1;
        exp_addr.push_back(32'h18);
        step(1);
        imem.req_ready   = 1'b0;
        ctrl.next_pc_sel = NEXT_PC_SEL_ALU_OUT;
        alu_out          = 32'h103;
        step(1);
        ctrl.next_pc_sel = NEXT_PC_SEL_PC_4;
        chk("drop_req_valid", imem.req_valid, 0);
        chk("drop_ifid_valid", ifid.valid, 0);
        step(1);
        chk("drop_req_valid2", imem.req_valid, 0);
        step(1);
        chk("redir_req_valid", imem.req_valid, 1);
        chk("redir_req_addr", imem.addr, 32'h100);
        chk("redir_ifid_valid", ifid.valid, 0);
        delay = 1;
        imem.req_ready = 1'b1;
        exp_addr.push_back(32'h100);
        push_ifid(32'h100);
        step(1);
        imem.req_ready = 1'b0;
        step(3);

        // Redirect coincident with the handshake at 0x20
        ctrl.next_pc_sel = NEXT_PC_SEL_ALU_OUT;
        alu_out          = 32'h20;
        step(1);
        chk("req_redirect_addr", imem.addr, 32'h20);
        alu_out        = 32'h40;
        delay          = 2;
        imem.req_ready = 1'b1;
        exp_addr.push_back(32'h20);
        step(1);
        imem.req_ready   = 1'b0;
        ctrl.next_pc_sel = NEXT_PC_SEL_PC_4;
        chk("hs_redir_no_req", imem.req_valid, 0);
        step(1);
        chk("hs_redir_no_req2", imem.req_valid, 0);
        step(1);
        chk("hs_redir_req_valid", imem.req_valid, 1);
        chk("hs_redir_req_addr", imem.addr, 32'h40);
        delay = 1;
        imem.req_ready = 1'b1;
        exp_addr.push_back(32'h40);
        push_ifid(32'h40);
        step(1);
        imem.req_ready = 1'b0;
        step(3);

        // pc wraps from 0xFFFF_FFFC to 0; unaligned target is word-aligned
        ctrl.next_pc_sel = NEXT_PC_SEL_ALU_OUT;
        alu_out          = 32'hFFFF_FFFF;
        step(1);
        ctrl.next_pc_sel = NEXT_PC_SEL_PC_4;
        chk("align_addr", imem.addr, 32'hFFFF_FFFC);
        imem.req_ready = 1'b1;
        exp_addr.push_back(32'hFFFF_FFFC);
        push_ifid(32'hFFFF_FFFC);
        step(1);
        imem.req_ready = 1'b0;
        step(1);
        chk("wrap_req_valid", imem.req_valid, 1);
        chk("wrap_req_addr", imem.addr, 32'h0);
        imem.req_ready = 1'b1;
        exp_addr.push_back(32'h0);
        push_ifid(32'h0);
        step(1);
        imem.req_ready = 1'b0;
        step(3);

        // Control-forced bubble: entry loads with valid=0
        ctrl.if_id_reg_valid = 1'b0;
        imem.req_ready = 1'b1;
        exp_addr.push_back(32'h4);
        step(1);
        imem.req_ready = 1'b0;
        step(1);
        chk("force_inv_valid", ifid.valid, 0);
        chk("force_inv_pc", ifid.pc, 32'h4);
        ctrl.if_id_reg_valid = 1'b1;
        step(2);

        // Asynchronous reset during WAIT; the stale response must be ignored
        delay = 4;
        imem.req_ready = 1'b1;
        exp_addr.push_back(32'h8);
        step(1);
        imem.req_ready = 1'b0;
        #3 reset_ni = 1'b0;
        #1;
        chk("async_rst_req_valid", imem.req_valid, 0);
        chk("async_rst_ifid_valid", ifid.valid, 0);
        chk("async_rst_ifid_pc", ifid.pc, 0);
        step(2);
        #2 reset_ni = 1'b1;
        step(2);
        chk("post_rst_ifid_valid", ifid.valid, 0);
        chk("post_rst_req_valid", imem.req_valid, 1);
        chk("post_rst_req_addr", imem.addr, RST_PC);
        delay = 1;
        imem.req_ready = 1'b1;
        exp_addr.push_back(RST_PC);
        push_ifid(RST_PC);
        step(1);
        imem.req_ready = 1'b0;
        step(3);

        chk("addr_queue_left", exp_addr.size(), 0);
        chk("ifid_queue_left", exp_pc.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
